// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pooling window sequencer.
package pool_pkg;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST,
    OUT
  } state_t;

  localparam logic signed [DW-1:0] ACC_INIT = {1'b1, {(DW-1){1'b0}}};

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction
endpackage

// File: rtl/pool_window_ctrl_if.sv
// Pooled-word output stream: valid/ready handshake with signed data.
interface pool_out_if
  import pool_pkg::*;
#(
  parameter int DIN_W = DW
);
  logic                    valid;
  logic                    ready;
  logic signed [DIN_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool_addr_gen.sv
// Window/element counters and RAM address adder for the pooling walk.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 2,
  parameter int STRIDE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base,
  input  logic              issue,
  input  logic              next_win,
  output logic [ADDR_W-1:0] addr,
  output logic              last_elem,
  output logic              last_win
);
  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);
  localparam int CW = 16;

  logic [CW-1:0]     kx, ky, ox, oy;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       row, col, off;

  assign last_elem = (kx == CW'(K - 1)) && (ky == CW'(K - 1));
  assign last_win  = (ox == CW'(OW - 1)) && (oy == CW'(OH - 1));

  assign row  = 32'(oy) * 32'(STRIDE) + 32'(ky);
  assign col  = 32'(ox) * 32'(STRIDE) + 32'(kx);
  assign off  = row * 32'(IMG_W) + col;
  assign addr = base_q + off[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
      base_q <= '0;
    end else if (clr) begin
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
      base_q <= base;
    end else begin
      if (issue) begin
        if (kx == CW'(K - 1)) begin
          kx <= '0;
          ky <= (ky == CW'(K - 1)) ? '0 : ky + 1'b1;
        end else begin
          kx <= kx + 1'b1;
        end
      end
      // Window position only moves once the pooled word has left
      if (next_win) begin
        if (ox == CW'(OW - 1)) begin
          ox <= '0;
          oy <= (oy == CW'(OH - 1)) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pool_window_ctrl.sv
// Max-pooling window sequencer; define POOL_RELU_EN to clamp negative
// maxima to zero on output.
module pool_window_ctrl
  import pool_pkg::*;
#(
  parameter int DIN_W  = DW,
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 2,
  parameter int STRIDE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic signed [DIN_W-1:0] rd_data,
  pool_out_if.master              out
);
  state_t                  state;
  logic                    rd_vld;
  logic signed [DIN_W-1:0] acc, mx;
  logic                    hs, clr, issue, next_win;
  logic                    last_elem, last_win;

  assign hs       = out.valid && out.ready;
  assign clr      = (state == IDLE) && start;
  assign issue    = (state == RUN);
  assign next_win = (state == OUT) && hs;
  assign mx       = (rd_data > acc) ? rd_data : acc;

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE)
  ) u_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .base      (base_addr),
    .issue     (issue),
    .next_win  (next_win),
    .addr      (rd_addr),
    .last_elem (last_elem),
    .last_win  (last_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_vld    <= 1'b0;
      acc       <= ACC_INIT;
      out.valid <= 1'b0;
      out.data  <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= rd_en;
      if (rd_vld && state == RUN) acc <= mx;
      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          rd_en <= 1'b1;
          acc   <= ACC_INIT;
        end
        RUN: if (last_elem) begin
          state <= LAST;
          rd_en <= 1'b0;
        end
        LAST: begin
`ifdef POOL_RELU_EN
          out.data <= mx[DIN_W-1] ? '0 : mx;
`else
          out.data <= mx;
`endif
          out.valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (hs) begin
          out.valid <= 1'b0;
          acc       <= ACC_INIT;
          if (last_win) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            rd_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
